// File: rtl/aer_arb_pkg.sv
// Shared field layout, event record and source id for the stereo AER event arbiter.
package aer_arb_pkg;

   localparam int Y_LSB   = 0;
   localparam int Y_W     = 8;
   localparam int X_LSB   = 8;
   localparam int X_W     = 9;
   localparam int SRC_BIT = 31;
   localparam int TS_W    = 32;

   // Only the X/Y bits of an incoming address word carry meaning.
   localparam int ADDR_W  = X_LSB + X_W;

   typedef struct packed {
      logic [X_W-1:0]  x;
      logic [Y_W-1:0]  y;
      logic [TS_W-1:0] ts;
   } aer_event_t;

   typedef enum logic {
      SRC_0 = 1'b0,
      SRC_1 = 1'b1
   } src_id_t;

   function automatic aer_event_t unpack_event(input logic [ADDR_W-1:0] addr,
                                               input logic [TS_W-1:0]   ts);
      aer_event_t ev;
      ev.x  = addr[X_LSB +: X_W];
      ev.y  = addr[Y_LSB +: Y_W];
      ev.ts = ts;
      return ev;
   endfunction

   function automatic logic [31:0] pack_word(input aer_event_t ev, input src_id_t src);
      logic [31:0] word;
      word                = '0;
      word[X_LSB +: X_W]  = ev.x;
      word[Y_LSB +: Y_W]  = ev.y;
      word[SRC_BIT]       = src;
      return word;
   endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// Single-clock event FIFO; pointers carry an extra wrap bit so all FIFO_DEPTH
// entries are usable. A push into a full FIFO is discarded even if a pop lands on the same edge.
module aer_event_fifo
   import aer_arb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_push,
   input  aer_event_t i_din,
   input  logic       i_pop,
   output aer_event_t o_dout,
   output logic       o_full,
   output logic       o_empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   aer_event_t  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        r_full;
   logic        r_empty;

   logic        w_push_ok;
   logic        w_pop_ok;
   logic [AW:0] w_wr_nxt;
   logic [AW:0] w_rd_nxt;

   assign w_push_ok = i_push && !r_full;
   assign w_pop_ok  = i_pop && !r_empty;
   assign w_wr_nxt  = r_wr_ptr + (AW+1)'(w_push_ok);
   assign w_rd_nxt  = r_rd_ptr + (AW+1)'(w_pop_ok);

   // Flags are registered from the next-state pointers so they describe the post-edge state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         r_full   <= (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                     (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
         r_empty  <= (w_wr_nxt == w_rd_nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_din;
      end
   end

   assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/aer_event_arbiter.sv
// Merges two AER event sources through per-source FIFOs and a round-robin arbiter
// into one registered output. Drop counters exist only when AER_ARB_DROP_CNT_EN is defined.
module aer_event_arbiter
   import aer_arb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DROP_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s0_valid,
   input  logic [31:0]           s0_data,
   input  logic [31:0]           s0_time,
   input  logic                  s1_valid,
   input  logic [31:0]           s1_data,
   input  logic [31:0]           s1_time,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [31:0]           m_data,
   output logic [31:0]           m_time,
   output logic [1:0]            fifo_full,
   output logic [DROP_CNT_W-1:0] drop_cnt0,
   output logic [DROP_CNT_W-1:0] drop_cnt1
);

   logic [1:0]  w_push;
   logic [1:0]  w_pop;
   logic [1:0]  w_full;
   logic [1:0]  w_empty;
   aer_event_t  w_din  [2];
   aer_event_t  w_dout [2];
   aer_event_t  w_gnt_ev;
   src_id_t     w_grant;
   logic        w_any;
   logic        w_load;
   logic        w_unused;

   logic        r_m_valid;
   logic [31:0] r_m_data;
   logic [31:0] r_m_time;
   src_id_t     r_last_grant;

   assign w_push   = {s1_valid, s0_valid};
   assign w_din[0] = unpack_event(s0_data[ADDR_W-1:0], s0_time);
   assign w_din[1] = unpack_event(s1_data[ADDR_W-1:0], s1_time);
   assign w_unused = ^{s0_data[31:ADDR_W], s1_data[31:ADDR_W]};

   for (genvar n = 0; n < 2; n++) begin : g_fifo
      aer_event_fifo #(
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .i_push  (w_push[n]),
         .i_din   (w_din[n]),
         .i_pop   (w_pop[n]),
         .o_dout  (w_dout[n]),
         .o_full  (w_full[n]),
         .o_empty (w_empty[n])
      );
   end

   // On a tie the source that did not win the previous load gets the grant.
   always_comb begin
      w_grant = SRC_0;
      if (!w_empty[0] && !w_empty[1]) begin
         w_grant = (r_last_grant == SRC_1) ? SRC_0 : SRC_1;
      end else if (!w_empty[1]) begin
         w_grant = SRC_1;
      end
   end

   // Output handshake: an event transfers on every edge where m_valid && m_ready;
   // while m_valid is high and m_ready low, m_data/m_time hold. The register
   // reloads whenever it is empty or being drained and some FIFO has data.
   assign w_any    = !(w_empty[0] && w_empty[1]);
   assign w_load   = (!r_m_valid || m_ready) && w_any;
   assign w_pop[0] = w_load && (w_grant == SRC_0);
   assign w_pop[1] = w_load && (w_grant == SRC_1);
   assign w_gnt_ev = (w_grant == SRC_1) ? w_dout[1] : w_dout[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_m_valid    <= 1'b0;
         r_m_data     <= '0;
         r_m_time     <= '0;
         r_last_grant <= SRC_1;
      end else if (w_load) begin
         r_m_valid    <= 1'b1;
         r_m_data     <= pack_word(w_gnt_ev, w_grant);
         r_m_time     <= w_gnt_ev.ts;
         r_last_grant <= w_grant;
      end else if (r_m_valid && m_ready) begin
         r_m_valid    <= 1'b0;
      end
   end

   assign m_valid   = r_m_valid;
   assign m_data    = r_m_data;
   assign m_time    = r_m_time;
   assign fifo_full = w_full;

`ifdef AER_ARB_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] r_drop_cnt0;
   logic [DROP_CNT_W-1:0] r_drop_cnt1;

   // A drop is any strobe that meets a full FIFO; counts stick at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_drop_cnt0 <= '0;
         r_drop_cnt1 <= '0;
      end else begin
         if (w_push[0] && w_full[0] && !(&r_drop_cnt0)) begin
            r_drop_cnt0 <= r_drop_cnt0 + DROP_CNT_W'(1);
         end
         if (w_push[1] && w_full[1] && !(&r_drop_cnt1)) begin
            r_drop_cnt1 <= r_drop_cnt1 + DROP_CNT_W'(1);
         end
      end
   end

   assign drop_cnt0 = r_drop_cnt0;
   assign drop_cnt1 = r_drop_cnt1;
`else
   assign drop_cnt0 = '0;
   assign drop_cnt1 = '0;
`endif

endmodule

// File: tb/tb_aer_event_arbiter.sv
// Directed bench for aer_event_arbiter: vector table for single-event and tie
// traffic, then hand-written overflow, backpressure, reset and saturation sequences.
module tb_aer_event_arbiter;

`ifdef AER_ARB_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        s0_valid, s1_valid, m_ready;
   logic [31:0] s0_data, s0_time, s1_data, s1_time;
   logic        m_valid;
   logic [31:0] m_data, m_time;
   logic [1:0]  fifo_full;
   logic [15:0] drop_cnt0, drop_cnt1;

   logic        sat_s1_valid;
   logic        sat_m_valid;
   logic [31:0] sat_m_data, sat_m_time;
   logic [1:0]  sat_fifo_full;
   logic [3:0]  sat_drop0, sat_drop1;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_word;

   typedef struct {
      logic        s0_v;
      logic [31:0] s0_d;
      logic [31:0] s0_t;
      logic        s1_v;
      logic [31:0] s1_d;
      logic [31:0] s1_t;
      logic        rdy;
      logic        e_valid;
      logic        chk_data;
      logic [31:0] e_data;
      logic [31:0] e_time;
      logic [1:0]  e_full;
   } vec_t;

   vec_t vecs[15];

   aer_event_arbiter #(.FIFO_DEPTH(4), .DROP_CNT_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .s0_valid  (s0_valid),
      .s0_data   (s0_data),
      .s0_time   (s0_time),
      .s1_valid  (s1_valid),
      .s1_data   (s1_data),
      .s1_time   (s1_time),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_time    (m_time),
      .fifo_full (fifo_full),
      .drop_cnt0 (drop_cnt0),
      .drop_cnt1 (drop_cnt1)
   );

   aer_event_arbiter #(.FIFO_DEPTH(4), .DROP_CNT_W(4)) dut_sat (
      .clk       (clk),
      .reset     (reset),
      .s0_valid  (1'b0),
      .s0_data   (32'h0),
      .s0_time   (32'h0),
      .s1_valid  (sat_s1_valid),
      .s1_data   (32'h0000_0055),
      .s1_time   (32'h0000_0055),
      .m_valid   (sat_m_valid),
      .m_ready   (1'b0),
      .m_data    (sat_m_data),
      .m_time    (sat_m_time),
      .fifo_full (sat_fifo_full),
      .drop_cnt0 (sat_drop0),
      .drop_cnt1 (sat_drop1)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic s0v, input logic [31:0] s0d, input logic [31:0] s0t,
                               input logic s1v, input logic [31:0] s1d, input logic [31:0] s1t,
                               input logic rdy, input logic ev, input logic cd,
                               input logic [31:0] ed, input logic [31:0] et, input logic [1:0] ef);
      vec_t v;
      v.s0_v = s0v; v.s0_d = s0d; v.s0_t = s0t;
      v.s1_v = s1v; v.s1_d = s1d; v.s1_t = s1t;
      v.rdy = rdy; v.e_valid = ev; v.chk_data = cd;
      v.e_data = ed; v.e_time = et; v.e_full = ef;
      return v;
   endfunction

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      s0_valid = 1'b0; s0_data = '0; s0_time = '0;
      s1_valid = 1'b0; s1_data = '0; s1_time = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      m_ready      = 1'b0;
      sat_s1_valid = 1'b0;
      reset        = 1'b1;
      step();
      step();
      reset        = 1'b0;
      step();
   endtask

   // scoreboard compare
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   initial begin
      // s0 upper address bits are junk and must be stripped; s1 words carry bit 31.
      vecs[0]  = mk(1, 32'h0000_1234, 32'h64,  0, 0, 0,                       1, 0, 1, 32'h0,         32'h0,   2'b00);
      vecs[1]  = mk(0, 0, 0,                   0, 0, 0,                       1, 1, 1, 32'h0000_1234, 32'h64,  2'b00);
      vecs[2]  = mk(0, 0, 0,                   0, 0, 0,                       1, 0, 0, 32'h0,         32'h0,   2'b00);
      vecs[3]  = mk(1, 32'hFFFE_0110, 32'h100, 1, 32'h0000_00AB, 32'h200,     1, 0, 0, 32'h0,         32'h0,   2'b00);
      vecs[4]  = mk(1, 32'hFFFE_0111, 32'h101, 1, 32'h0000_00AB, 32'h201,     1, 1, 1, 32'h8000_00AB, 32'h200, 2'b00);
      vecs[5]  = mk(1, 32'hFFFE_0112, 32'h102, 1, 32'h0000_00AB, 32'h202,     1, 1, 1, 32'h0000_0110, 32'h100, 2'b00);
      vecs[6]  = mk(1, 32'hFFFE_0113, 32'h103, 1, 32'h0000_00AB, 32'h203,     1, 1, 1, 32'h8000_00AB, 32'h201, 2'b00);
      vecs[7]  = mk(1, 32'hFFFE_0114, 32'h104, 1, 32'h0000_00AB, 32'h204,     1, 1, 1, 32'h0000_0111, 32'h101, 2'b00);
      vecs[8]  = mk(0, 0, 0,                   0, 0, 0,                       1, 1, 1, 32'h8000_00AB, 32'h202, 2'b00);
      vecs[9]  = mk(0, 0, 0,                   0, 0, 0,                       1, 1, 1, 32'h0000_0112, 32'h102, 2'b00);
      vecs[10] = mk(0, 0, 0,                   0, 0, 0,                       1, 1, 1, 32'h8000_00AB, 32'h203, 2'b00);
      vecs[11] = mk(0, 0, 0,                   0, 0, 0,                       1, 1, 1, 32'h0000_0113, 32'h103, 2'b00);
      vecs[12] = mk(0, 0, 0,                   0, 0, 0,                       1, 1, 1, 32'h8000_00AB, 32'h204, 2'b00);
      vecs[13] = mk(0, 0, 0,                   0, 0, 0,                       1, 1, 1, 32'h0000_0114, 32'h104, 2'b00);
      vecs[14] = mk(0, 0, 0,                   0, 0, 0,                       1, 0, 0, 32'h0,         32'h0,   2'b00);

      idle_inputs();
      m_ready      = 1'b0;
      sat_s1_valid = 1'b0;
      reset        = 1'b1;
      step();
      step();
      check("rst_m_valid", {31'b0, m_valid}, 32'd0);
      check("rst_m_data", m_data, 32'h0);
      check("rst_m_time", m_time, 32'h0);
      check("rst_fifo_full", {30'b0, fifo_full}, 32'd0);
      check("rst_drop_cnt0", {16'b0, drop_cnt0}, 32'd0);
      check("rst_drop_cnt1", {16'b0, drop_cnt1}, 32'd0);
      reset = 1'b0;
      step();

      // single event then alternating tie traffic
      for (int i = 0; i < 15; i++) begin
         s0_valid = vecs[i].s0_v; s0_data = vecs[i].s0_d; s0_time = vecs[i].s0_t;
         s1_valid = vecs[i].s1_v; s1_data = vecs[i].s1_d; s1_time = vecs[i].s1_t;
         m_ready  = vecs[i].rdy;
         step();
         check($sformatf("vec%0d_m_valid", i), {31'b0, m_valid}, {31'b0, vecs[i].e_valid});
         if (vecs[i].chk_data) begin
            check($sformatf("vec%0d_m_data", i), m_data, vecs[i].e_data);
            check($sformatf("vec%0d_m_time", i), m_time, vecs[i].e_time);
         end
         check($sformatf("vec%0d_fifo_full", i), {30'b0, fifo_full}, {30'b0, vecs[i].e_full});
      end
      idle_inputs();

      // overflow: six events with the consumer stalled, then one more into a full FIFO while popping
      do_reset();
      for (int k = 0; k < 6; k++) begin
         s0_valid = 1'b1;
         s0_data  = 32'h0000_1000 + 32'(k);
         s0_time  = 32'h0000_0500 + 32'(k);
         if (k < 5) exp_q.push_back(32'h0000_1000 + 32'(k));
         step();
      end
      idle_inputs();
      check("ovf_fifo_full", {30'b0, fifo_full}, 32'h1);
      check("ovf_drop_cnt0", {16'b0, drop_cnt0}, DROP_EN ? 32'd1 : 32'd0);
      for (int k = 0; k < 5; k++) begin
         exp_word = exp_q.pop_front();
         check($sformatf("ovf_valid%0d", k), {31'b0, m_valid}, 32'd1);
         check($sformatf("ovf_data%0d", k), m_data, exp_word);
         check($sformatf("ovf_time%0d", k), m_time, 32'h0000_0500 + 32'(k));
         m_ready = 1'b1;
         if (k == 0) begin
            s0_valid = 1'b1;
            s0_data  = 32'h0001_FFFF;
            s0_time  = 32'h0000_0BAD;
         end
         step();
         s0_valid = 1'b0;
      end
      check("ovf_drained", {31'b0, m_valid}, 32'd0);
      check("ovf_fifo_full_after", {30'b0, fifo_full}, 32'd0);
      check("ovf_drop_cnt0_final", {16'b0, drop_cnt0}, DROP_EN ? 32'd2 : 32'd0);

      // backpressure: output must hold for 10 stalled cycles while another event queues
      do_reset();
      s1_valid = 1'b1; s1_data = 32'h0001_2345; s1_time = 32'h0000_CAFE;
      step();
      idle_inputs();
      step();
      check("bp_valid_start", {31'b0, m_valid}, 32'd1);
      for (int c = 0; c < 10; c++) begin
         if (c == 3) begin
            s0_valid = 1'b1; s0_data = 32'h0000_0777; s0_time = 32'h0000_0777;
         end
         step();
         s0_valid = 1'b0;
         check($sformatf("bp_valid%0d", c), {31'b0, m_valid}, 32'd1);
         check($sformatf("bp_data%0d", c), m_data, 32'h8001_2345);
         check($sformatf("bp_time%0d", c), m_time, 32'h0000_CAFE);
      end
      m_ready = 1'b1;
      step();
      check("bp_next_valid", {31'b0, m_valid}, 32'd1);
      check("bp_next_data", m_data, 32'h0000_0777);
      check("bp_next_time", m_time, 32'h0000_0777);
      step();
      check("bp_idle", {31'b0, m_valid}, 32'd0);

      // reset mid-stream with events queued on both sources
      do_reset();
      for (int k = 0; k < 4; k++) begin
         s0_valid = (k < 3);
         s0_data  = 32'h0000_2000 + 32'(k);
         s0_time  = 32'h0000_0600 + 32'(k);
         s1_valid = 1'b1;
         s1_data  = 32'h0000_3000 + 32'(k);
         s1_time  = 32'h0000_0700 + 32'(k);
         step();
      end
      idle_inputs();
      check("mid_fifo_full", {30'b0, fifo_full}, 32'h2);
      check("mid_valid", {31'b0, m_valid}, 32'd1);
      check("mid_first_tie", m_data, 32'h0000_2000);
      #2;
      reset = 1'b1;
      #1;
      check("mid_async_valid", {31'b0, m_valid}, 32'd0);
      check("mid_async_full", {30'b0, fifo_full}, 32'd0);
      check("mid_async_data", m_data, 32'h0);
      step();
      step();
      reset   = 1'b0;
      m_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         check($sformatf("mid_stale%0d", c), {31'b0, m_valid}, 32'd0);
         check($sformatf("mid_full%0d", c), {30'b0, fifo_full}, 32'd0);
      end

      // saturation on a 4-bit counter: 5 events absorbed, then 20 drops, then 5 more
      do_reset();
      sat_s1_valid = 1'b1;
      for (int k = 0; k < 25; k++) step();
      check("sat_drop1_20", {28'b0, sat_drop1}, DROP_EN ? 32'hF : 32'h0);
      check("sat_fifo_full", {30'b0, sat_fifo_full}, 32'h2);
      check("sat_m_valid", {31'b0, sat_m_valid}, 32'd1);
      check("sat_m_data", sat_m_data, 32'h8000_0055);
      check("sat_m_time", sat_m_time, 32'h0000_0055);
      for (int k = 0; k < 5; k++) step();
      sat_s1_valid = 1'b0;
      check("sat_drop1_hold", {28'b0, sat_drop1}, DROP_EN ? 32'hF : 32'h0);
      check("sat_drop0", {28'b0, sat_drop0}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
